// File: rtl/gpo_ctrl.sv
// Addressed GPO register file with SET/CLR/TOG write modes and an optional timed pulse engine (GPO_PULSE_EN).
// Latency: one cycle; a write on edge t shows on gpo_out, busy and rd_data after edge t.
// Backpressure: none, every write is accepted; rd_data is a combinational mux of register state.
module gpo_ctrl #(
    parameter int             WIDTH     = 32,
    parameter int             CNT_W     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] gpo_out,
    output logic             busy
);

    localparam logic [2:0] A_DATA  = 3'd0;
    localparam logic [2:0] A_SET   = 3'd1;
    localparam logic [2:0] A_CLR   = 3'd2;
    localparam logic [2:0] A_TOG   = 3'd3;
    localparam logic [2:0] A_PMASK = 3'd4;
    localparam logic [2:0] A_PLEN  = 3'd5;
    localparam logic [2:0] A_STAT  = 3'd6;

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_next;
    logic [WIDTH-1:0] gpo_q;
    logic [WIDTH-1:0] inv_next;

    always_comb begin
        data_next = data_q;
        if (we) begin
            case (addr)
                A_DATA:  data_next = wr_data;
                A_SET:   data_next = data_q | wr_data;
                A_CLR:   data_next = data_q & ~wr_data;
                A_TOG:   data_next = data_q ^ wr_data;
                default: data_next = data_q;
            endcase
        end
    end

`ifdef GPO_PULSE_EN
    logic [WIDTH-1:0] pmask_q;
    logic [WIDTH-1:0] amask_q;
    logic [WIDTH-1:0] amask_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic [CNT_W-1:0] len;
    logic             busy_q;

    assign len = CNT_W'(wr_data);

    // A PULSE_LEN write overrides the running decrement: N restarts, 0 aborts.
    always_comb begin
        amask_next = amask_q;
        count_next = '0;
        if (we && addr == A_PLEN) begin
            count_next = len;
            if (len != '0) begin
                amask_next = pmask_q;
            end
        end else if (count_q != '0) begin
            count_next = count_q - 1'b1;
        end
    end

    assign inv_next = (count_next != '0) ? amask_next : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pmask_q <= '0;
            amask_q <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (we && addr == A_PMASK) begin
                pmask_q <= wr_data;
            end
            amask_q <= amask_next;
            count_q <= count_next;
            busy_q  <= (count_next != '0);
        end
    end

    assign busy = busy_q;
`else
    assign inv_next = '0;
    assign busy     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
            gpo_q  <= RESET_VAL;
        end else begin
            data_q <= data_next;
            gpo_q  <= data_next ^ inv_next;
        end
    end

    assign gpo_out = gpo_q;

    always_comb begin
        rd_data = '0;
        case (addr)
            A_DATA, A_SET, A_CLR, A_TOG: rd_data = data_q;
`ifdef GPO_PULSE_EN
            A_PMASK: rd_data = pmask_q;
            A_PLEN:  rd_data = WIDTH'(count_q);
            A_STAT:  rd_data = WIDTH'(busy_q);
`endif
            default: rd_data = '0;
        endcase
    end

endmodule

// File: doc/gpo_ctrl.md
Name: gpo_ctrl

Overview:
- Parametrised general-purpose output controller. Successor to the single-register GPO.
- Adds an addressed register file with atomic SET/CLR/TOGGLE write modes, readback, and a timed pulse engine that inverts masked bits for a programmed number of cycles.
- Sits on the core's memory-mapped peripheral bus and drives board-level output pins (LEDs, debug strobes).

Parameters:
- WIDTH, 32, width of the output port and data registers (1..32).
- CNT_W, 16, width of the pulse length counter.
- RESET_VAL, 0, value loaded into the DATA register and gpo_out at reset (WIDTH bits).

Ports:
- clk  in  1  system clock, all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- we  in  1  write strobe, one write per cycle it is high.
- addr  in  3  register select.
- wr_data  in  WIDTH  write data; PULSE_LEN uses the low CNT_W bits.
- rd_data  out  WIDTH  combinational readback of the register selected by addr.
- gpo_out  out  WIDTH  registered output pins.
- busy  out  1  registered; high while a pulse is active.

Behaviour:
- Register map:
  - 0 DATA: write replaces.
  - 1 SET: DATA |= wr_data.
  - 2 CLR: DATA &= ~wr_data.
  - 3 TOG: DATA ^= wr_data.
  - 4 PULSE_MASK: plain write.
  - 5 PULSE_LEN: write starts a pulse.
  - 6, 7: reserved; writes ignored, reads return 0.
- Reset (rst_n low at a clock edge):
  - DATA = RESET_VAL, gpo_out = RESET_VAL.
  - PULSE_MASK = 0, active mask = 0, count = 0, busy = 0.
  - Reset overrides a simultaneous we.
  - Reset mid-pulse aborts the pulse; gpo_out is RESET_VAL on the following cycle.
- Output equation:
  - gpo_out <= DATA_next ^ (count_next != 0 ? amask_next : 0).
  - Latency is one cycle: a write on edge t is visible on gpo_out and rd_data after edge t.
- Pulse engine (states IDLE / ACTIVE, encoded by count != 0):
  - IDLE + write PULSE_LEN with N != 0: count = N, amask = PULSE_MASK (the value before this edge), busy = 1, go ACTIVE.
  - IDLE + write N = 0: no effect.
  - ACTIVE: count decrements by 1 each cycle. When count reaches 0, busy = 0 and amask bits restore, returning to IDLE.
  - Net effect: masked bits are inverted on gpo_out for exactly N consecutive cycles, starting the cycle after the write.
  - ACTIVE + write PULSE_LEN N != 0: restart with count = N and re-latched amask; the decrement for that cycle is discarded.
  - ACTIVE + write N = 0: abort; count = 0 and outputs restore next cycle.
  - PULSE_MASK writes during ACTIVE affect only the next pulse.
  - DATA/SET/CLR/TOG writes during ACTIVE update DATA normally. gpo_out continues to show DATA ^ amask.
  - A pulse never modifies DATA.
  - N = 2^CNT_W - 1 is supported with no wrap; count never underflows below 0.
- rd_data:
  - addr 0–3 return DATA.
  - addr 4 returns PULSE_MASK.
  - addr 5 returns count, zero-extended.
  - addr 6 returns {0, busy}.
  - addr 7 returns 0.
- Width rules: wr_data bits above WIDTH are absent. A PULSE_LEN write uses wr_data[CNT_W-1:0] (or all bits if WIDTH < CNT_W).

Optional Feature:
- GPO_PULSE_EN:
  - Defined: pulse engine, PULSE_MASK, and PULSE_LEN exist as described.
  - Undefined:
    - No counter or mask flops.
    - Writes to addr 4/5 are ignored and reads of addr 4/5/6 return 0.
    - busy is tied 0 and gpo_out <= DATA_next.

Test Plan:
- Reset with RESET_VAL = 32'h0000_00A5, then write DATA = 32'h1234_5678 in the same cycle as rst_n = 0 -> gpo_out = 32'h0000_00A5 after the edge; after release and a write, gpo_out = 32'h1234_5678 one cycle later.
- DATA = 32'hF0F0_0000, then SET 32'h0000_000F, CLR 32'h1000_0000, TOG 32'h0000_0003 on consecutive cycles -> gpo_out = F0F0_000F, E0F0_000F, E0F0_000C on successive cycles.
- Write PULSE_MASK = 32'h1 and DATA = 0, then PULSE_LEN = 5 -> gpo_out[0] = 1 and busy = 1 for exactly 5 cycles; rd_data@5 counts 5,4,3,2,1, then 0 with busy = 0.
- During a 10-cycle pulse, write SET 32'h1 at cycle 3 -> gpo_out[0] drops to 0 for the remaining pulse cycles, then returns to 1. Also write PULSE_LEN = 4 at cycle 6 -> pulse extends to 4 cycles from that point.
- Write PULSE_LEN = 0 while ACTIVE -> busy = 0 and mask bits restored on the next cycle. Assert rst_n = 0 mid-pulse -> count = 0 and gpo_out = RESET_VAL.
- Build with GPO_PULSE_EN undefined: write PULSE_LEN = 8 -> busy stays 0, gpo_out unchanged, rd_data@4/5/6 = 0.
